dac_scheduler: RTL and testbench
================================

Name: dac_scheduler

Overview:
- Shares the single 24-bit SPI DAC transmitter between four sample sources (oscillator/CV channels).
- Latches the newest sample per channel and picks pending channels in round-robin order.
- Builds the 24-bit DAC word and pulses the transmitter's send input.
- Tracks transaction progress by monitoring the transmitter's chip-select output, so no busy signal is needed from the transmitter.

Parameters:
- CMD, 4'b0011, DAC command nibble placed in word bits [23:20] (write and update channel).
- START_TIMEOUT, 8'd64, clocks allowed in WAIT_START for chip select to go low before the issue is abandoned.
- GAP_CYCLES, 8'd40, idle clocks enforced after chip select returns high, before the next issue. Must be ≥ 2× the transmitter's SPI half-period count.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_in_0..sample_in_3  input  16 each  channel sample values.
- sample_valid  input  4  per-channel one-cycle strobe; bit n qualifies sample_in_n.
- spi_cs  input  1  chip-select feedback from the DAC SPI transmitter (low = transfer in progress).
- dac_data  output  24  word to the transmitter's data input.
- dac_send  output  1  one-cycle send pulse to the transmitter.
- active_channel  output  2  channel currently issued or in flight.
- busy  output  1  high in every state except IDLE.
- overrun  output  4  sticky per channel: a new sample overwrote an unsent one.
- timeout_err  output  1  sticky: a WAIT_START timeout occurred.

Behaviour:
- Reset values: dac_data=0, dac_send=0, active_channel=0, busy=0, overrun=0, timeout_err=0. Pending flags cleared, sample registers=0, round-robin pointer=0, state=IDLE, counters=0. Reset asserted mid-transfer aborts immediately to IDLE; the transmitter is reset separately.
- Sample capture, every cycle, independent of state:
  - sample_valid[n]=1 stores sample_in_n into sample register n and sets pending[n] on the next edge.
  - If pending[n] was already 1 and the channel was not selected in that same cycle, overrun[n] sets. Latest value wins.
- Round-robin selection: search starts at the pointer and wraps 3→0. The first pending channel is chosen. After a selection the pointer becomes channel+1 mod 4.
- States:
  - IDLE:
    - No pending channels: stay.
    - Otherwise, in one edge: select channel c, dac_data <= {CMD, 4'b0001<<c, sample_c}, active_channel <= c, clear pending[c], go to ISSUE.
    - If sample_valid[c] arrives in the same cycle: the new value is stored, pending[c] stays 1, and overrun is not set. The issued word carries the old value.
  - ISSUE: dac_send=1 for exactly this one cycle. Load the timeout counter. Go to WAIT_START.
  - WAIT_START:
    - spi_cs==0: go to WAIT_DONE.
    - Otherwise the counter decrements. At zero: set timeout_err, set pending[active_channel] again (the sample is retried, not lost), go to IDLE.
  - WAIT_DONE: stay while spi_cs==0. When spi_cs==1, load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: decrement each cycle. When the counter reaches 0, go to IDLE.
- Timing and stability:
  - dac_data and active_channel stay stable from the IDLE selection until the next selection.
  - Latency from sample_valid to dac_send, all channels idle: 3 clocks (capture, select, issue).
- Arithmetic and boundaries:
  - All counters saturate at 0; the gap counter must not wrap.
  - If spi_cs is low while in IDLE (external fault), it is ignored.
  - Simultaneous strobes on several channels are all captured in the same cycle.

Test Plan:
- Single sample: reset, then sample_valid=4'b0100 with sample_in_2=16'hABCD → dac_send pulses 3 clocks later with dac_data=24'h34ABCD. After a modelled cs low/high, busy drops GAP_CYCLES+1 clocks after cs rises.
- Round-robin: all four strobed together with values 1,2,3,4 → issue order ch0,ch1,ch2,ch3. Address nibbles 1,2,4,8. No overrun.
- Overrun: two strobes on ch1 (16'h1111 then 16'h2222) while ch0 is in flight → overrun=4'b0010, and only 16'h2222 is sent for ch1.
- Same-cycle select plus strobe: ch3 strobed on the exact IDLE-select edge → old value sent, a second transfer sends the new value, overrun stays 0.
- Timeout: spi_cs held high after dac_send → timeout_err=1 after 64 clocks, the same channel is reissued, and the word is unchanged.
- Reset mid-operation: assert reset during WAIT_DONE → all outputs return to reset values immediately, and pending is cleared.

Source files
------------

// File: rtl/dac_scheduler.sv
// Round-robin scheduler sharing one 24-bit SPI DAC transmitter between four sample channels.
// Transfer progress is tracked from the transmitter's chip-select, so no busy handshake is needed.
module dac_scheduler #(
  parameter logic [3:0] CMD           = 4'b0011,
  parameter logic [7:0] START_TIMEOUT = 8'd64,
  parameter logic [7:0] GAP_CYCLES    = 8'd40
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [15:0] sample_in_0,
  input  logic [15:0] sample_in_1,
  input  logic [15:0] sample_in_2,
  input  logic [15:0] sample_in_3,
  input  logic [3:0]  sample_valid,
  input  logic        spi_cs,
  output logic [23:0] dac_data,
  output logic        dac_send,
  output logic [1:0]  active_channel,
  output logic        busy,
  output logic [3:0]  overrun,
  output logic        timeout_err
);

  // state      | meaning
  // IDLE       | pick next pending channel, build word
  // ISSUE      | one-cycle send pulse, arm start timeout
  // WAIT_START | wait for chip select low, abandon on timeout
  // WAIT_DONE  | transfer in flight until chip select high
  // GAP        | enforced idle spacing before next issue
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state, state_nx;
  logic [3:0][15:0]  samples, sample_bus;
  logic [3:0]        pending, pending_nx, overrun_nx;
  logic [1:0]        ptr, ptr_nx, sel_ch, active_nx;
  logic              sel_found, select;
  logic [7:0]        cnt, cnt_nx;
  logic [23:0]       data_nx;
  logic              timeout_nx;

  assign sample_bus = {sample_in_3, sample_in_2, sample_in_1, sample_in_0};
  assign dac_send   = (state == ISSUE);
  assign busy       = (state != IDLE);

  // Scan from the highest offset down so the nearest pending channel wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (pending[ptr + 2'(i)]) begin
        sel_found = 1'b1;
        sel_ch    = ptr + 2'(i);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    overrun_nx = overrun;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    data_nx    = dac_data;
    active_nx  = active_channel;
    timeout_nx = timeout_err;
    select     = 1'b0;

    case (state)
      IDLE: begin
        if (sel_found) begin
          select              = 1'b1;
          data_nx             = {CMD, 4'b0001 << sel_ch, samples[sel_ch]};
          active_nx           = sel_ch;
          ptr_nx              = sel_ch + 2'd1;
          pending_nx[sel_ch]  = 1'b0;
          state_nx            = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx   = START_TIMEOUT;
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (!spi_cs) begin
          state_nx = WAIT_DONE;
        end else if (cnt <= 8'd1) begin
          cnt_nx                     = 8'd0;
          timeout_nx                 = 1'b1;
          pending_nx[active_channel] = 1'b1;
          state_nx                   = IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      WAIT_DONE: begin
        if (spi_cs) begin
          cnt_nx   = GAP_CYCLES;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (cnt <= 8'd1) begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A strobe on the channel being selected this cycle replaces, not overruns.
    for (int n = 0; n < 4; n++) begin
      if (sample_valid[n]) begin
        if (pending[n] && !(select && (sel_ch == 2'(n))))
          overrun_nx[n] = 1'b1;
        pending_nx[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      samples        <= '0;
      pending        <= '0;
      overrun        <= '0;
      ptr            <= '0;
      cnt            <= '0;
      dac_data       <= '0;
      active_channel <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nx;
      pending        <= pending_nx;
      overrun        <= overrun_nx;
      ptr            <= ptr_nx;
      cnt            <= cnt_nx;
      dac_data       <= data_nx;
      active_channel <= active_nx;
      timeout_err    <= timeout_nx;
      for (int n = 0; n < 4; n++) begin
        if (sample_valid[n])
          samples[n] <= sample_bus[n];
      end
    end
  end

endmodule

// File: tb/tb_dac_scheduler.sv
// Bench for dac_scheduler: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized strobes and transmitter timing.
module tb_dac_scheduler;

  localparam int START_TO = 64;
  localparam int GAP      = 40;

  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in_0 = '0, sample_in_1 = '0, sample_in_2 = '0, sample_in_3 = '0;
  logic [3:0]  sample_valid = '0;
  logic        spi_cs;
  logic [23:0] dac_data;
  logic        dac_send;
  logic [1:0]  active_channel;
  logic        busy;
  logic [3:0]  overrun;
  logic        timeout_err;

  dac_scheduler dut (
    .clock_in(clock_in), .reset(reset),
    .sample_in_0(sample_in_0), .sample_in_1(sample_in_1),
    .sample_in_2(sample_in_2), .sample_in_3(sample_in_3),
    .sample_valid(sample_valid), .spi_cs(spi_cs),
    .dac_data(dac_data), .dac_send(dac_send), .active_channel(active_channel),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [23:0] sent_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: automatic responder or manual chip-select level.
  bit tx_auto = 1'b0;
  bit rand_mode = 1'b0;
  logic cs_manual = 1'b1;
  logic tx_cs = 1'b1;
  int tx_st = 0;
  int tx_cnt = 0;
  assign spi_cs = tx_auto ? tx_cs : cs_manual;

  always @(negedge clock_in) begin
    if (reset) begin
      tx_st = 0;
      tx_cs = 1'b1;
    end else begin
      case (tx_st)
        0: if (dac_send === 1'b1) begin
             if (!(rand_mode && $urandom_range(0, 7) == 0)) begin
               tx_st  = 1;
               tx_cnt = rand_mode ? int'($urandom_range(0, 12)) : 1;
               if (rand_mode && $urandom_range(0, 15) == 0) tx_cnt = int'($urandom_range(55, 75));
             end
           end
        1: if (tx_cnt == 0) begin
             tx_cs  = 1'b0;
             tx_st  = 2;
             tx_cnt = rand_mode ? int'($urandom_range(1, 30)) : 4;
           end else tx_cnt--;
        default: if (tx_cnt == 0) begin
             tx_cs = 1'b1;
             tx_st = 0;
           end else tx_cnt--;
      endcase
    end
  end

  // Reference model: phase of the current transaction plus cycles spent in it.
  // phase 0 idle, 1 send pulse, 2 awaiting cs low, 3 transfer, 4 spacing gap
  int          m_phase, m_elapsed, m_ptr, m_ch, m_sel;
  int          m_samp[4];
  logic [3:0]  m_pend, m_old, m_ovr;
  logic [23:0] m_word;
  bit          m_terr;

  function automatic logic [15:0] samp_in(input int n);
    case (n)
      0: return sample_in_0;
      1: return sample_in_1;
      2: return sample_in_2;
      default: return sample_in_3;
    endcase
  endfunction

  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_ptr = 0; m_ch = 0;
      m_pend = '0; m_ovr = '0; m_word = '0; m_terr = 1'b0;
      for (int n = 0; n < 4; n++) m_samp[n] = 0;
    end else begin
      m_old = m_pend;
      m_sel = -1;
      case (m_phase)
        0: begin
          for (int i = 0; i < 4; i++)
            if (m_sel < 0 && m_old[(m_ptr + i) % 4]) m_sel = (m_ptr + i) % 4;
          if (m_sel >= 0) begin
            m_word = 24'(32'h30_0000 + (32'h1 << (16 + m_sel)) + m_samp[m_sel]);
            m_ch = m_sel;
            m_ptr = (m_sel + 1) % 4;
            m_pend[m_sel] = 1'b0;
            m_phase = 1;
          end
        end
        1: begin m_phase = 2; m_elapsed = 0; end
        2: begin
          if (spi_cs == 1'b0) m_phase = 3;
          else if (m_elapsed == START_TO - 1) begin
            m_terr = 1'b1;
            m_pend[m_ch] = 1'b1;
            m_phase = 0;
          end else m_elapsed++;
        end
        3: if (spi_cs == 1'b1) begin m_phase = 4; m_elapsed = 0; end
        default: begin
          if (m_elapsed == GAP - 1) m_phase = 0;
          else m_elapsed++;
        end
      endcase
      for (int n = 0; n < 4; n++) begin
        if (sample_valid[n]) begin
          if (m_old[n] && m_sel != n) m_ovr[n] = 1'b1;
          m_pend[n] = 1'b1;
          m_samp[n] = int'(samp_in(n));
        end
      end
    end
  end

  always @(negedge clock_in) begin
    if (chk_en) begin
      chk("dac_data", 32'(dac_data), 32'(m_word));
      chk("dac_send", 32'(dac_send), 32'(m_phase == 1));
      chk("active_channel", 32'(active_channel), 32'(m_ch));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      if (dac_send === 1'b1) sent_q.push_back(dac_data);
    end
  end

  task automatic do_reset();
    @(negedge clock_in); #2 reset = 1'b1;
    sample_valid = '0;
    @(negedge clock_in); #2 reset = 1'b0;
    sent_q.delete();
  endtask

  task automatic wait_send(input int max, input string name);
    int k = 0;
    while (dac_send !== 1'b1 && k < max) begin @(negedge clock_in); k++; end
    chk(name, 32'(dac_send), 32'd1);
  endtask

  task automatic wait_sent(input int n, input int max, input string name);
    int k = 0;
    while (sent_q.size() < n && k < max) begin @(negedge clock_in); k++; end
    chk(name, 32'(sent_q.size()), 32'(n));
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [15:0] v3);
    sample_valid = mask;
    sample_in_0 = v0; sample_in_1 = v1; sample_in_2 = v2; sample_in_3 = v3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock_in);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock_in);
    chk("reset_dac_data", 32'(dac_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_active", 32'(active_channel), 32'd0);

    // cs low while idle must be ignored; then single sample on ch2
    tx_auto = 1'b0; cs_manual = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("idle_cs_fault_busy", 32'(busy), 32'd0);
    cs_manual = 1'b1;
    @(negedge clock_in);
    strobe(4'b0100, 16'h0, 16'h0, 16'hABCD, 16'h0);
    @(negedge clock_in);
    sample_valid = '0;
    chk("single_send_not_early", 32'(dac_send), 32'd0);
    @(negedge clock_in);
    chk("single_send", 32'(dac_send), 32'd1);
    chk("single_word", 32'(dac_data), 32'h34ABCD);
    @(negedge clock_in); cs_manual = 1'b0;
    repeat (3) @(negedge clock_in);
    cs_manual = 1'b1;
    repeat (GAP) @(negedge clock_in);
    chk("gap_busy_still_high", 32'(busy), 32'd1);
    @(negedge clock_in);
    chk("gap_busy_dropped", 32'(busy), 32'd0);

    // round robin over all four channels
    do_reset();
    tx_auto = 1'b1; rand_mode = 1'b0;
    @(negedge clock_in);
    strobe(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
    @(negedge clock_in); sample_valid = '0;
    wait_sent(4, 1000, "rr_count");
    if (sent_q.size() >= 4) begin
      chk("rr_word0", 32'(sent_q[0]), 32'h310001);
      chk("rr_word1", 32'(sent_q[1]), 32'h320002);
      chk("rr_word2", 32'(sent_q[2]), 32'h340003);
      chk("rr_word3", 32'(sent_q[3]), 32'h380004);
    end
    chk("rr_overrun", 32'(overrun), 32'd0);

    // overrun on ch1 while ch0 in flight
    do_reset();
    @(negedge clock_in);
    strobe(4'b0001, 16'h5555, 16'h0, 16'h0, 16'h0);
    @(negedge clock_in); sample_valid = '0;
    wait_send(10, "ovr_first_send");
    @(negedge clock_in); strobe(4'b0010, 16'h0, 16'h1111, 16'h0, 16'h0);
    @(negedge clock_in); strobe(4'b0010, 16'h0, 16'h2222, 16'h0, 16'h0);
    @(negedge clock_in); sample_valid = '0;
    chk("ovr_flag", 32'(overrun), 32'b0010);
    wait_sent(2, 500, "ovr_count");
    if (sent_q.size() >= 2) begin
      chk("ovr_word0", 32'(sent_q[0]), 32'h315555);
      chk("ovr_word1", 32'(sent_q[1]), 32'h382222 ^ 32'h0A0000);
    end
    repeat (100) @(negedge clock_in);
    chk("ovr_no_third", 32'(sent_q.size()), 32'd2);

    // ch3 strobed again on its own selection edge
    do_reset();
    @(negedge clock_in);
    strobe(4'b1000, 16'h0, 16'h0, 16'h0, 16'hAAAA);
    @(negedge clock_in);
    strobe(4'b1000, 16'h0, 16'h0, 16'h0, 16'hBBBB);
    @(negedge clock_in); sample_valid = '0;
    wait_sent(2, 500, "same_cycle_count");
    if (sent_q.size() >= 2) begin
      chk("same_cycle_word0", 32'(sent_q[0]), 32'h38AAAA);
      chk("same_cycle_word1", 32'(sent_q[1]), 32'h38BBBB);
    end
    chk("same_cycle_overrun", 32'(overrun), 32'd0);

    // start timeout: cs never drops
    do_reset();
    tx_auto = 1'b0; cs_manual = 1'b1;
    @(negedge clock_in);
    strobe(4'b0010, 16'h0, 16'h1234, 16'h0, 16'h0);
    @(negedge clock_in); sample_valid = '0;
    @(negedge clock_in);
    chk("to_send", 32'(dac_send), 32'd1);
    repeat (START_TO) @(negedge clock_in);
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clock_in);
    chk("to_flag", 32'(timeout_err), 32'd1);
    @(negedge clock_in);
    chk("to_resend", 32'(dac_send), 32'd1);
    chk("to_resend_word", 32'(dac_data), 32'h321234);
    chk("to_resend_ch", 32'(active_channel), 32'd1);

    // reset during a transfer, with another channel still pending
    do_reset();
    tx_auto = 1'b0; cs_manual = 1'b1;
    @(negedge clock_in);
    strobe(4'b0101, 16'h0101, 16'h0, 16'h7777, 16'h0);
    @(negedge clock_in); sample_valid = '0;
    @(negedge clock_in);
    @(negedge clock_in); cs_manual = 1'b0;
    repeat (2) @(negedge clock_in);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_data", 32'(dac_data), 32'd0);
    chk("rst_mid_send", 32'(dac_send), 32'd0);
    @(negedge clock_in); #2 reset = 1'b0; cs_manual = 1'b1;
    repeat (5) @(negedge clock_in);
    chk("rst_mid_pending_cleared", 32'(busy), 32'd0);

    // randomized strobes and transmitter timing against the model
    do_reset();
    tx_auto = 1'b1; rand_mode = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock_in);
      sample_valid = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      sample_in_0 = 16'($urandom); sample_in_1 = 16'($urandom);
      sample_in_2 = 16'($urandom); sample_in_3 = 16'($urandom);
    end
    @(negedge clock_in); sample_valid = '0;
    repeat (5) @(negedge clock_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
